// File: rtl/x_micro_sequencer_loader.sv
// rtl/x_micro_sequencer_loader.sv - host byte-stream command decoder that loads and runs x_micro_sequencer
// Accepts WRITE/RUN/STATUS commands on the RX stream and answers each with one TX response byte.
module x_micro_sequencer_loader #(
  parameter int BYTE_TIMEOUT = 1000,
  parameter int START_WAIT   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_seq_wen,
  output logic [8:0]  o_seq_waddr,
  output logic [3:0]  o_seq_wcmd,
  output logic [35:0] o_seq_wdata,
  output logic        o_seq_start,
  input  logic        i_seq_busy
);

  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam int SW = $clog2(START_WAIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BYTE_TIMEOUT - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(START_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WRITE, START, WAIT_HI, WAIT_LO, RESP
  } state_t;

  state_t        state, state_n;
  logic [2:0]    byte_cnt, byte_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [SW-1:0] wait_cnt, wait_cnt_n;
  logic [8:0]    addr, addr_n;
  logic [31:0]   word, word_n;
  logic [7:0]    tx_data_n;
  logic [8:0]    waddr_n;
  logic [3:0]    wcmd_n;
  logic [35:0]   wdata_n;
  logic [39:0]   full_word;
  logic          accept;

  assign o_rx_ready  = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign accept      = i_rx_valid && o_rx_ready;
  assign o_tx_valid  = (state == RESP);
  assign o_seq_wen   = (state == WRITE);
  assign o_seq_start = (state == START);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      wait_cnt    <= '0;
      addr        <= '0;
      word        <= '0;
      o_tx_data   <= '0;
      o_seq_waddr <= '0;
      o_seq_wcmd  <= '0;
      o_seq_wdata <= '0;
    end else begin
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      wait_cnt    <= wait_cnt_n;
      addr        <= addr_n;
      word        <= word_n;
      o_tx_data   <= tx_data_n;
      o_seq_waddr <= waddr_n;
      o_seq_wcmd  <= wcmd_n;
      o_seq_wdata <= wdata_n;
    end
  end

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    tmo_cnt_n  = tmo_cnt;
    wait_cnt_n = wait_cnt;
    addr_n     = addr;
    word_n     = word;
    tx_data_n  = o_tx_data;
    waddr_n    = o_seq_waddr;
    wcmd_n     = o_seq_wcmd;
    wdata_n    = o_seq_wdata;
    full_word  = {word, i_rx_data};

    case (state)
      IDLE: begin
        if (accept) begin
          case (i_rx_data)
            8'hA1: begin
              state_n    = ADDR;
              byte_cnt_n = '0;
              tmo_cnt_n  = '0;
            end
            8'hA2: begin
              if (i_seq_busy) begin
                state_n   = RESP;
                tx_data_n = 8'hEE;
              end else begin
                state_n = START;
              end
            end
            8'hA3: begin
              state_n   = RESP;
              tx_data_n = {7'b0, i_seq_busy};
            end
            default: begin
              state_n   = RESP;
              tx_data_n = 8'hFF;
            end
          endcase
        end
      end
      ADDR: begin
        if (accept) begin
          tmo_cnt_n = '0;
          if (byte_cnt == 3'd0) begin
            addr_n[8]  = i_rx_data[0];
            byte_cnt_n = 3'd1;
          end else begin
            addr_n[7:0] = i_rx_data;
            byte_cnt_n  = '0;
            state_n     = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          tmo_cnt_n = '0;
          word_n    = full_word[31:0];
          if (byte_cnt == 3'd4) begin
            byte_cnt_n = '0;
            waddr_n    = addr;
            wdata_n    = full_word[39:4];
            wcmd_n     = full_word[3:0];
            state_n    = WRITE;
          end else begin
            byte_cnt_n = byte_cnt + 3'd1;
          end
        end
      end
      WRITE: begin
        state_n   = RESP;
        tx_data_n = 8'h55;
      end
      START: begin
        state_n    = WAIT_HI;
        wait_cnt_n = '0;
      end
      WAIT_HI: begin
        if (i_seq_busy) begin
          state_n = WAIT_LO;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n   = RESP;
          tx_data_n = 8'hEF;
        end else begin
          wait_cnt_n = wait_cnt + SW'(1);
        end
      end
      WAIT_LO: begin
        if (!i_seq_busy) begin
          state_n   = RESP;
          tx_data_n = 8'h5A;
        end
      end
      RESP: begin
        if (i_tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A stalled command abandons its partial address/word so no write can follow.
    if ((state == ADDR || state == DATA) && !accept) begin
      if (tmo_cnt == TMO_LAST) begin
        state_n    = RESP;
        tx_data_n  = 8'hFE;
        tmo_cnt_n  = '0;
        byte_cnt_n = '0;
        addr_n     = '0;
        word_n     = '0;
      end else begin
        tmo_cnt_n = tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_x_micro_sequencer_loader.sv
// tb/tb_x_micro_sequencer_loader.sv - directed bench for x_micro_sequencer_loader
// Drives command bytes, models sequencer busy by hand and checks every response byte and strobe.
module tb_x_micro_sequencer_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        o_seq_wen;
  logic [8:0]  o_seq_waddr;
  logic [3:0]  o_seq_wcmd;
  logic [35:0] o_seq_wdata;
  logic        o_seq_start;
  logic        i_seq_busy;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int start_cnt = 0;

  x_micro_sequencer_loader #(.BYTE_TIMEOUT(1000), .START_WAIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_seq_wen(o_seq_wen), .o_seq_waddr(o_seq_waddr), .o_seq_wcmd(o_seq_wcmd),
    .o_seq_wdata(o_seq_wdata), .o_seq_start(o_seq_start), .i_seq_busy(i_seq_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_seq_wen) wen_cnt++;
    if (o_seq_start) start_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    n = 0;
    while (!o_rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!o_rx_ready) check("send_ready", o_rx_ready, 1);
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!o_tx_valid && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, o_tx_valid, 1);
    check(tag, o_tx_data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    i_tx_ready = 1'b1; i_seq_busy = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_wen", o_seq_wen, 0);
    check("rst_start", o_seq_start, 0);
    check("rst_waddr", o_seq_waddr, 0);
    check("rst_wdata", o_seq_wdata, 0);
    check("rst_wcmd", o_seq_wcmd, 0);
    i_rst = 1'b0;
    tick();
    check("rx_ready_after_rst", o_rx_ready, 1);

    // Write word 0x123456789A to 0x123
    send(8'hA1); send(8'h01); send(8'h23);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h9A);
    check("wr_wen", o_seq_wen, 1);
    check("wr_waddr", o_seq_waddr, 9'h123);
    check("wr_wdata", o_seq_wdata, 36'h123456789);
    check("wr_wcmd", o_seq_wcmd, 4'hA);
    check("wr_rx_ready", o_rx_ready, 0);
    tick();
    check("wr_wen_low", o_seq_wen, 0);
    check("wr_resp_valid", o_tx_valid, 1);
    check("wr_resp", o_tx_data, 8'h55);
    check("wr_waddr_hold", o_seq_waddr, 9'h123);
    tick();
    check("wr_wen_count", wen_cnt, 1);

    // Top address, high address bits above bit 0 ignored
    send(8'hFF); send(8'hFF);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hF3);
    send(8'hA1); send(8'hFF); send(8'hFF);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hF3);
    check("wr2_waddr", o_seq_waddr, 9'h1FF);
    check("wr2_wdata", o_seq_wdata, 36'hFFFFFFFFF);
    check("wr2_wcmd", o_seq_wcmd, 4'h3);
    resp("wr2_resp", 8'h55);

    // Preceding FF bytes were unknown opcodes, each answered with FF
    check("wr2_wen_count", wen_cnt, 2);

    // RUN with sequencer going busy then idle
    send(8'hA2);
    check("run_start", o_seq_start, 1);
    check("run_no_resp", o_tx_valid, 0);
    tick();
    check("run_start_pulse", o_seq_start, 0);
    i_seq_busy = 1'b1;
    repeat (20) tick();
    check("run_wait_lo", o_tx_valid, 0);
    i_seq_busy = 1'b0;
    tick();
    check("run_done_valid", o_tx_valid, 1);
    check("run_done", o_tx_data, 8'h5A);
    tick();
    check("run_start_count", start_cnt, 1);

    // RUN while busy is refused
    i_seq_busy = 1'b1;
    send(8'hA2);
    check("busy_valid", o_tx_valid, 1);
    check("busy_resp", o_tx_data, 8'hEE);
    tick();
    i_seq_busy = 1'b0;
    check("busy_no_start", start_cnt, 1);

    // RUN with busy never rising
    send(8'hA2);
    check("nb_start", o_seq_start, 1);
    repeat (4) tick();
    check("nb_not_yet", o_tx_valid, 0);
    tick();
    check("nb_valid", o_tx_valid, 1);
    check("nb_resp", o_tx_data, 8'hEF);
    tick();
    check("nb_start_count", start_cnt, 2);

    // Byte timeout mid-data
    send(8'hA1); send(8'h00); send(8'h05); send(8'h11);
    repeat (999) tick();
    check("tmo_not_yet", o_tx_valid, 0);
    check("tmo_still_ready", o_rx_ready, 1);
    tick();
    check("tmo_valid", o_tx_valid, 1);
    check("tmo_resp", o_tx_data, 8'hFE);
    tick();
    check("tmo_no_wen", wen_cnt, 2);
    send(8'hA3);
    resp("status_idle", 8'h00);
    i_seq_busy = 1'b1;
    send(8'hA3);
    resp("status_busy", 8'h01);
    i_seq_busy = 1'b0;

    // TX back-pressure holds response and blocks RX
    i_tx_ready = 1'b0;
    send(8'h42);
    check("bp_valid", o_tx_valid, 1);
    check("bp_resp", o_tx_data, 8'hFF);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hA3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", o_tx_valid, 1);
      check("bp_hold_data", o_tx_data, 8'hFF);
      check("bp_rx_blocked", o_rx_ready, 0);
    end
    i_tx_ready = 1'b1;
    tick();
    check("bp_released", o_tx_valid, 0);
    check("bp_rx_ready", o_rx_ready, 1);
    tick();
    i_rx_valid = 1'b0;
    check("bp_next_valid", o_tx_valid, 1);
    check("bp_next_resp", o_tx_data, 8'h00);
    tick();

    // Reset mid-command
    send(8'hA1); send(8'h00); send(8'h05);
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_waddr", o_seq_waddr, 0);
    check("mid_rst_tx_data", o_tx_data, 0);
    tick(); tick();
    i_rst = 1'b0;
    repeat (20) tick();
    check("mid_rst_no_wen", wen_cnt, 2);
    check("mid_rst_no_start", start_cnt, 2);
    check("mid_rst_ready", o_rx_ready, 1);
    check("mid_rst_no_resp", o_tx_valid, 0);
    send(8'hA3);
    resp("mid_rst_status", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
